sram_req_bridge: RTL and testbench
==================================

# sram_req_bridge

Converts a chiplab-style sram-like request interface (req/addr_ok, data_ok) into the strobe-level port set of the single-port byte-writable on-chip SRAM, and returns in-order responses through a 2-entry response buffer with consumer backpressure. It sits directly upstream of the SP SRAM wrapper in the SoC memory path. It absorbs the SRAM's one-cycle read latency and its hold-last-read output behaviour.

## Interface
- AW, 16, SRAM word-address width; the SRAM holds 2^AW 32-bit words.
- clk  input  1  single clock; all state updates on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- req  input  1  master request valid.
- wr  input  1  1 = write, 0 = read.
- addr  input  32  byte address; bits [AW+1:2] select the word, other bits are ignored (aliasing).
- wstrb  input  4  byte-lane write enables; used only when wr=1.
- wdata  input  32  write data.
- addr_ok  output  1  request accepted this cycle (req && addr_ok = handshake).
- data_ok  output  1  response valid at buffer head.
- data_ready  input  1  consumer takes response (data_ok && data_ready = pop).
- rdata  output  32  read data for a read response; 0 for a write response.
- ram_addr  output  AW  to SRAM ADDR; equals addr[AW+1:2], combinational.
- ram_wdata  output  32  to SRAM WDATA; equals wdata, combinational.
- ram_wren  output  4  to SRAM WREN; wstrb when accepted write, else 0.
- ram_cs  output  1  to SRAM CS; 1 only in a handshake cycle.
- ram_rdata  input  32  from SRAM RDATA; valid the cycle after a read strobe and held until the next read.

## Operation
- Stage P (1 entry: p_valid, p_wr) records the op accepted in the previous cycle.
- Response buffer: 2-entry in-order FIFO of 32-bit data; head drives rdata, data_ok = non-empty.
- Accept condition: addr_ok = req && resetn && (count + p_valid - pop) < 2, where pop = data_ok && data_ready. This is a combinational path from data_ready to addr_ok (intended).
- Handshake cycle N: ram_cs=1; ram_wren = wr ? wstrb : 4'b0; p_valid<=1, p_wr<=wr.
- No handshake: ram_cs=0, ram_wren=0, p_valid<=0.
- Cycle N+1, p_valid=1: push (p_wr ? 32'h0 : ram_rdata) into FIFO. ram_rdata is sampled only when p_valid && !p_wr.
- Simultaneous push and pop: count unchanged; the head advances and the new entry goes to the tail.
- Credit rule guarantees a push never meets a full FIFO. An overflow is a design error; the verification environment asserts against it.
- Writes with wstrb=0 still strobe CS, change no memory, and return a response.
- Responses leave in exact acceptance order; reads and writes are never reordered.

## Timing
- Reset (resetn=0, async): p_valid=0, count=0, FIFO pointers 0. Outputs: data_ok=0, rdata=0, addr_ok=0, ram_cs=0, ram_wren=0. ram_addr and ram_wdata follow their inputs and are don't-care while ram_cs=0.
- Reset asserted mid-operation drops all in-flight and buffered responses. No write in its handshake cycle at the reset edge is guaranteed.
- Latency: a handshake in cycle N gives data_ok=1 in cycle N+2 (FIFO was empty), with registered rdata.
- Throughput: 1 op/cycle sustained when data_ready=1 continuously.
- With data_ready=0, at most 2 ops are outstanding (buffer + P). addr_ok deasserts until a pop.
- Read-after-write, same word (write N, read N+1): the read returns the new data at N+3.
- Back-to-back reads: each response matches its own address. A stale ram_rdata is never captured for a write slot.

## Test plan
- Reset: hold resetn=0 with req=1 -> addr_ok=0, ram_cs=0, data_ok=0, rdata=0; release, then idle -> no activity.
- Write 0x00000010 with wdata=0xDEADBEEF, wstrb=4'hF, then read 0x10 next cycle -> ram_wren=F then 0; read response rdata=0xDEADBEEF at handshake+2; write response (rdata=0) precedes it.
- Partial write wstrb=4'b0101, wdata=0x11223344 over word 0xAAAAAAAA, then read -> 0xAA22AA44.
- Backpressure: data_ready=0 and 4 reads issued -> exactly 2 accepted, addr_ok=0 after. Release data_ready -> remaining 2 accepted, 4 responses in order with correct data.
- Streaming: 64 alternating writes/reads to random addresses with data_ready=1 -> one handshake per cycle, responses match a scoreboard model, no FIFO overflow.
- Aliasing and reset: read addr=0xFFFC0010 with AW=16 -> same word as 0x10. Assert resetn mid-burst -> data_ok drops immediately, and the first post-reset read returns correct data.

Source files
------------

// File: rtl/sram_req_bridge.sv
// sram_req_bridge: sram-like req/addr_ok/data_ok bridge onto a 1-cycle-latency single-port byte-writable SRAM
//
// Ports:
//   clk_i          clock, all state on rising edge
//   resetn_i       asynchronous active-low reset
//   req_i          master request valid
//   wr_i           1 = write, 0 = read
//   addr_i         byte address, word index taken from [AW+1:2]
//   wstrb_i        byte-lane write enables (writes only)
//   wdata_i        write data
//   addr_ok_o      request accepted this cycle
//   data_ok_o      response valid at buffer head
//   data_ready_i   consumer takes the head response
//   rdata_o        head response data (0 for write responses)
//   ram_addr_o     SRAM word address
//   ram_wdata_o    SRAM write data
//   ram_wren_o     SRAM byte write enables
//   ram_cs_o       SRAM chip select
//   ram_rdata_i    SRAM read data, valid the cycle after a read strobe
module sram_req_bridge #(
    parameter int AW = 16
) (
    input  logic          clk_i,
    input  logic          resetn_i,
    input  logic          req_i,
    input  logic          wr_i,
    input  logic [31:0]   addr_i,
    input  logic [3:0]    wstrb_i,
    input  logic [31:0]   wdata_i,
    output logic          addr_ok_o,
    output logic          data_ok_o,
    input  logic          data_ready_i,
    output logic [31:0]   rdata_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [31:0]   ram_wdata_o,
    output logic [3:0]    ram_wren_o,
    output logic          ram_cs_o,
    input  logic [31:0]   ram_rdata_i
);
    logic        p_valid_q, p_valid_d;
    logic        p_wr_q, p_wr_d;
    logic [1:0]  count_q, count_d;
    logic        wptr_q, rptr_q;
    logic [31:0] buf_q [2];
    logic        pop, push, hs;
    logic [2:0]  occ;
    logic        unused_addr;

    assign unused_addr = ^{addr_i[31:AW+2], addr_i[1:0]};

    assign data_ok_o = count_q != 2'd0;
    assign pop       = data_ok_o && data_ready_i;
    assign push      = p_valid_q;
    // Slots committed after this edge: buffered + in flight in P - leaving now.
    // Accepting only below 2 guarantees the P entry always finds room.
    assign occ       = {1'b0, count_q} + {2'b0, p_valid_q} - {2'b0, pop};
    assign addr_ok_o = req_i && resetn_i && occ < 3'd2;
    assign hs        = req_i && addr_ok_o;

    assign ram_addr_o  = addr_i[AW+1:2];
    assign ram_wdata_o = wdata_i;
    assign ram_cs_o    = hs;
    assign ram_wren_o  = (hs && wr_i) ? wstrb_i : 4'h0;
    assign rdata_o     = data_ok_o ? buf_q[rptr_q] : 32'h0;

    always_comb begin
        p_valid_d = hs;
        p_wr_d    = hs ? wr_i : p_wr_q;
        count_d   = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            p_valid_q <= 1'b0;
            p_wr_q    <= 1'b0;
            count_q   <= 2'd0;
            wptr_q    <= 1'b0;
            rptr_q    <= 1'b0;
        end else begin
            p_valid_q <= p_valid_d;
            p_wr_q    <= p_wr_d;
            count_q   <= count_d;
            if (push)
                wptr_q <= ~wptr_q;
            if (pop)
                rptr_q <= ~rptr_q;
        end
    end

    // Write slots push 0 so a stale held ram_rdata never leaks into a write response.
    always_ff @(posedge clk_i) begin
        if (push)
            buf_q[wptr_q] <= p_wr_q ? 32'h0 : ram_rdata_i;
    end
endmodule

// File: tb/tb_sram_req_bridge.sv
// tb_sram_req_bridge: randomized and directed bench with a transaction-level reference model
module tb_sram_req_bridge;
    logic        clk = 1'b0;
    logic        resetn, req, wr, data_ready;
    logic [31:0] addr, wdata, rdata, ram_wdata;
    logic [31:0] ram_rdata = 32'h0;
    logic [3:0]  wstrb, ram_wren;
    logic        addr_ok, data_ok, ram_cs;
    logic [15:0] ram_addr;

    always #5 clk = ~clk;

    sram_req_bridge #(.AW(16)) dut (
        .clk_i(clk), .resetn_i(resetn), .req_i(req), .wr_i(wr), .addr_i(addr),
        .wstrb_i(wstrb), .wdata_i(wdata), .addr_ok_o(addr_ok), .data_ok_o(data_ok),
        .data_ready_i(data_ready), .rdata_o(rdata), .ram_addr_o(ram_addr),
        .ram_wdata_o(ram_wdata), .ram_wren_o(ram_wren), .ram_cs_o(ram_cs),
        .ram_rdata_i(ram_rdata)
    );

    typedef struct {
        logic [31:0] d;
        int          rdy;
    } rsp_t;

    int          n_cmp = 0, n_bad = 0, cyc = 0, waits = 0;
    logic [31:0] sram [int];
    logic [31:0] ref_mem [int];
    logic [31:0] got [$];
    rsp_t        q [$];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] srd(input int a);
        return sram.exists(a) ? sram[a] : 32'h0;
    endfunction

    function automatic logic [31:0] mrd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // SRAM behaviour: one-cycle read latency, read data held until the next read.
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_wren != 4'h0)
                sram[int'(ram_addr)] = merge(srd(int'(ram_addr)), ram_wdata, ram_wren);
            else
                ram_rdata <= srd(int'(ram_addr));
        end
    end

    // Reference model: list of accepted, not-yet-consumed responses; each becomes
    // visible two cycles after acceptance, at most two may be outstanding.
    always @(negedge clk) begin
        logic e_dok, e_pop, e_acc;
        int   idx;
        if (!resetn) begin
            chk("rst_addr_ok", addr_ok, 0);
            chk("rst_data_ok", data_ok, 0);
            chk("rst_cs", ram_cs, 0);
            chk("rst_wren", ram_wren, 0);
            chk("rst_rdata", rdata, 0);
            q.delete();
        end else begin
            e_dok = q.size() > 0 && q[0].rdy <= cyc;
            e_pop = e_dok && data_ready;
            e_acc = req && (q.size() - int'(e_pop)) < 2;
            idx   = int'(addr[17:2]);
            chk("data_ok", data_ok, e_dok);
            chk("addr_ok", addr_ok, e_acc);
            chk("ram_cs", ram_cs, e_acc);
            chk("ram_wren", ram_wren, (e_acc && wr) ? wstrb : 4'h0);
            if (e_dok)
                chk("rdata", rdata, q[0].d);
            if (e_acc) begin
                chk("ram_addr", ram_addr, addr[17:2]);
                if (wr)
                    chk("ram_wdata", ram_wdata, wdata);
            end
            if (e_pop) begin
                got.push_back(rdata);
                void'(q.pop_front());
            end
            if (e_acc) begin
                if (wr) begin
                    ref_mem[idx] = merge(mrd(idx), wdata, wstrb);
                    q.push_back('{32'h0, cyc + 2});
                end else
                    q.push_back('{mrd(idx), cyc + 2});
            end
        end
        cyc++;
    end

    task automatic op(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        logic acc = 1'b0;
        req = 1'b1; wr = w; addr = a; wstrb = s; wdata = d;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = addr_ok;
            @(posedge clk);
            #1;
            waits++;
        end
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL op_timeout: addr %h never accepted", a);
        end
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int   n;
        logic acc;
        resetn = 1'b0; req = 1'b1; wr = 1'b0; addr = 32'h10; wstrb = 4'h0; wdata = 32'h0; data_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        idle(3);

        got.delete();
        op(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        op(1'b0, 32'h10, 4'h0, 32'h0);
        idle(6);
        chk("raw_count", got.size(), 2);
        chk("raw_wr_rsp", got[0], 32'h0);
        chk("raw_rd_rsp", got[1], 32'hDEADBEEF);

        got.delete();
        op(1'b1, 32'h20, 4'hF, 32'hAAAAAAAA);
        op(1'b1, 32'h20, 4'b0101, 32'h11223344);
        op(1'b0, 32'h20, 4'h0, 32'h0);
        idle(6);
        chk("partial_count", got.size(), 3);
        chk("partial_rd", got[2], 32'hAA22AA44);

        got.delete();
        op(1'b0, 32'hFFFC0010, 4'h0, 32'h0);
        idle(6);
        chk("alias_rd", got[0], 32'hDEADBEEF);

        for (int i = 0; i < 4; i++)
            op(1'b1, 32'h40 + 4 * i, 4'hF, 32'hB0000000 + i);
        idle(6);
        got.delete();
        data_ready = 1'b0;
        n = 0;
        req = 1'b1; wr = 1'b0; addr = 32'h40;
        repeat (8) begin
            @(negedge clk);
            acc = addr_ok;
            @(posedge clk);
            #1;
            if (acc) begin
                n++;
                addr = 32'h40 + 4 * n;
            end
        end
        chk("bp_accepted", n, 2);
        chk("bp_addr_ok_low", addr_ok, 0);
        data_ready = 1'b1;
        for (int i = 0; i < 20 && n < 4; i++) begin
            @(negedge clk);
            acc = addr_ok;
            @(posedge clk);
            #1;
            if (acc) begin
                n++;
                addr = 32'h40 + 4 * n;
                req = n < 4;
            end
        end
        idle(6);
        chk("bp_count", got.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("bp_data", got[i], 32'hB0000000 + i);

        waits = 0;
        for (int i = 0; i < 64; i++)
            op(i % 2 == 0, $urandom & 32'hFFFC001C, 4'($urandom), $urandom);
        idle(6);
        chk("stream_cycles", waits, 64);

        repeat (300) begin
            req = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            addr = $urandom & 32'hFFFC001C;
            wstrb = 4'($urandom);
            wdata = $urandom;
            data_ready = $urandom_range(0, 3) != 0;
            @(posedge clk);
            #1;
        end
        data_ready = 1'b1;
        idle(6);

        req = 1'b1; wr = 1'b0; addr = 32'h10;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_data_ok", data_ok, 1);
        resetn = 1'b0;
        #1;
        chk("mid_rst_data_ok", data_ok, 0);
        chk("mid_rst_addr_ok", addr_ok, 0);
        chk("mid_rst_cs", ram_cs, 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        idle(2);
        got.delete();
        op(1'b0, 32'h44, 4'h0, 32'h0);
        idle(6);
        chk("post_rst_count", got.size(), 1);
        chk("post_rst_rd", got[0], 32'hB0000001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
